seven_seg_demux: RTL and testbench
==================================

# seven_seg_demux

Receive-side counterpart of the six-digit multiplexed seven-segment display bus. Samples the shared active-low segment lines and per-digit active-low anode strobes, filters switching glitches, and rebuilds the six per-digit segment patterns plus their decoded hex values. Used for on-board loopback self-test of the display path and as a capture monitor for the display output pins.

## Interface
- `NUM_DIGITS`, default 6: anode strobe count; this revision supports only 6.
- `STABLE_CYCLES`, default 4, minimum 2: consecutive `clk` cycles a sampled {an, seg} pair must hold before capture.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seg_in`  in  7: shared segment bus, active low; bit0 = a … bit6 = g. Asynchronous to `clk`.
- `an_in`  in  6: anode strobes, active low; bit k selects digit k. Asynchronous to `clk`.
- `digit_seg`  out  42: captured raw patterns; digit k at bits [7k+6:7k].
- `digit_hex`  out  24: decoded nibble per digit; digit k at bits [4k+3:4k].
- `digit_valid`  out  6: bit k is 1 when digit k holds a recognised hex glyph.
- `frame_done`  out  1: one-cycle pulse when every digit has been captured since the previous pulse.
- `an_error`  out  1: one-cycle pulse on each stable window with two or more anodes low.

## Operation
- Input stage: 2-flop synchroniser on all 13 bits, followed by a `prev` register for change detection.
- Stability counter `hold_cnt`:
  - Cleared to 0 on any edge where the synchronised value differs from `prev`.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- Classifier FSM, evaluated on the window value:
  - IDLE: all anodes high (blank period).
  - SETTLING: value changing, or `hold_cnt` below `STABLE_CYCLES`.
  - CAPTURED: capture done; wait for the next change.
- Transitions:
  - Any change → SETTLING.
  - SETTLING with `hold_cnt` reaching `STABLE_CYCLES` → action below, then CAPTURED. If all anodes are high, go to IDLE instead.
  - A change in CAPTURED or IDLE → SETTLING.
- Capture action, taken exactly once per stable window:
  - Exactly one anode k low: write `digit_seg[k]` ← seg, `digit_hex[k]`/`digit_valid[k]` ← decode(seg), set `seen[k]`.
  - Two or more anodes low: pulse `an_error`; no register is written.
  - All anodes high: no action.
- Decode (active low, bit0 = a): 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F. Any other pattern, including blank 0x7F: hex 0, valid 0. Raw `digit_seg` is still updated.
- Frame tracking:
  - When a capture makes `seen` all ones, pulse `frame_done` on that same edge and clear `seen` to 0.
  - Recapturing an already-seen digit does not pulse `frame_done`.
  - Capture order is irrelevant.
- Reset, asynchronous, all registers:
  - `digit_seg` = all 7'h7F, `digit_hex` = 0, `digit_valid` = 0, `frame_done` = 0, `an_error` = 0, `seen` = 0.
  - FSM = IDLE, `hold_cnt` = 0, synchronisers = all ones.
  - Reset mid-window discards the partial window.

## Timing
- Pin change sampled at edge E1 → in synchroniser output after E2.
- Capture, and all output updates, on edge E(2+`STABLE_CYCLES`); E6 at default.
- `frame_done` and `an_error` are registered and high for exactly one cycle, coincident with the capture edge.
- Pulses shorter than `STABLE_CYCLES` cycles after synchronisation are ignored.
- A window held indefinitely produces one capture only.
- Back-to-back windows of exactly `STABLE_CYCLES` cycles each are all captured.

## Structure
- Shared package `seven_seg_pkg`:
  - Glyph constants (including `SEG_BLANK` = 7'h7F)
  - `seg2hex` function returning {valid, nibble}
  - FSM state enum
  - The encoder-side hex→seg table is defined in the same package, so both directions share one glyph set.
- One sub-module: `sync_stability_filter`. It contains the synchroniser, `prev`, `hold_cnt` and a `stable_strobe` output, parameterised on width and `STABLE_CYCLES`.

## Test plan
- Reset, then hold an_in=6'h3F → `digit_seg` all 0x7F, `digit_valid`=0, no pulses ever.
- an_in=6'h3E with seg 0x40, held 10 cycles → on E6 `digit_hex[3:0]`=0, `digit_valid[0]`=1, exactly one capture.
- Sweep digits 0..5 with 0x79, 0x24, 0x30, 0x19, 0x12, 0x08, 8 cycles each → `digit_hex`=24'hA54321; `frame_done` pulses once, on digit 5's capture.
- 2-cycle glitch an_in=6'h3D / seg 0x00 between stable windows → digit 1 unchanged.
- an_in=6'h3C held 8 cycles → `an_error` one pulse; no digit written; `seen` unchanged.
- Pattern 0x7F on digit 2 → `digit_seg` digit 2 = 0x7F, `valid[2]`=0. Assert `rst_n` during SETTLING → all outputs return to reset values immediately.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// Module : seven_seg_pkg
// Brief  : Shared glyph set (both directions), decoder and classifier states.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seven_seg_pkg;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Encoder-side table; element i is the glyph for nibble i
  localparam logic [15:0][6:0] HEX2SEG = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_CAPTURED = 2'd2
  } state_e;

  // Returns {valid, nibble}; unrecognised patterns give {0, 4'h0}
  function automatic logic [4:0] seg2hex(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX2SEG[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_stability_filter.sv
// ---------------------------------------------------------------------------
// Module : sync_stability_filter
// Brief  : 2-flop synchroniser plus change detector and stability counter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_stability_filter #(
  parameter int WIDTH         = 13,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic             stable_strobe
);

  localparam int              CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
  // The count clears on the edge after the change reaches the synchroniser
  // output, so the S-th stable edge is the one where the count leaves S-2.
  localparam logic [CNT_W-1:0] STROBE_AT = CNT_W'(STABLE_CYCLES - 2);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] sync1_d, sync2_d, prev_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    sync1_d    = din;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    changed    = (sync2_q != prev_q);
    hold_cnt_d = hold_cnt_q;
    if (changed) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
    stable_strobe = !changed && (hold_cnt_q == STROBE_AT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      prev_q     <= '1;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign dout = sync2_q;

endmodule

`default_nettype wire

// File: rtl/seven_seg_demux.sv
// ---------------------------------------------------------------------------
// Module : seven_seg_demux
// Brief  : Rebuilds per-digit patterns from a multiplexed 7-seg display bus.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seven_seg_demux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [7*NUM_DIGITS-1:0] digit_seg,
  output logic [4*NUM_DIGITS-1:0] digit_hex,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    an_error
);

  localparam int W = NUM_DIGITS + 7;

  logic [W-1:0]          window;
  logic                  changed, stable_strobe;
  logic [NUM_DIGITS-1:0] an_low;
  logic [6:0]            seg;
  logic                  one_low, multi_low, cap_en;
  logic [4:0]            dec;

  state_e state_q, state_d;

  logic [7*NUM_DIGITS-1:0] digit_seg_q, digit_seg_d;
  logic [4*NUM_DIGITS-1:0] digit_hex_q, digit_hex_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_next;
  logic                    frame_done_q, frame_done_d;
  logic                    an_error_q, an_error_d;

  sync_stability_filter #(
    .WIDTH         (W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           ({an_in, seg_in}),
    .dout          (window),
    .changed       (changed),
    .stable_strobe (stable_strobe)
  );

  assign an_low    = ~window[W-1:7];
  assign seg       = window[6:0];
  assign one_low   = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign multi_low = (an_low != '0) && !one_low;
  assign dec       = seg2hex(seg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (changed) begin
      state_d = ST_SETTLING;
    end else if (state_q == ST_SETTLING && stable_strobe) begin
      state_d = (an_low == '0) ? ST_IDLE : ST_CAPTURED;
    end
  end

  // Only the SETTLING->stable transition captures, so a held window fires once
  always_comb begin
    cap_en = (state_q == ST_SETTLING) && stable_strobe;
  end

  always_comb begin
    digit_seg_d   = digit_seg_q;
    digit_hex_d   = digit_hex_q;
    digit_valid_d = digit_valid_q;
    seen_d        = seen_q;
    seen_next     = seen_q | an_low;
    frame_done_d  = 1'b0;
    an_error_d    = 1'b0;
    if (cap_en && one_low) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an_low[k]) begin
          digit_seg_d[7*k +: 7] = seg;
          digit_hex_d[4*k +: 4] = dec[3:0];
          digit_valid_d[k]      = dec[4];
        end
      end
      if (&seen_next) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d       = seen_next;
      end
    end else if (cap_en && multi_low) begin
      an_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_seg_q   <= {NUM_DIGITS{SEG_BLANK}};
      digit_hex_q   <= '0;
      digit_valid_q <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      an_error_q    <= 1'b0;
    end else begin
      digit_seg_q   <= digit_seg_d;
      digit_hex_q   <= digit_hex_d;
      digit_valid_q <= digit_valid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      an_error_q    <= an_error_d;
    end
  end

  assign digit_seg   = digit_seg_q;
  assign digit_hex   = digit_hex_q;
  assign digit_valid = digit_valid_q;
  assign frame_done  = frame_done_q;
  assign an_error    = an_error_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_demux.sv
// ---------------------------------------------------------------------------
// Module : tb_seven_seg_demux
// Brief  : Directed self-checking bench for seven_seg_demux.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seven_seg_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [5:0]  an_in = 6'h3F;
  logic [41:0] digit_seg;
  logic [23:0] digit_hex;
  logic [5:0]  digit_valid;
  logic        frame_done;
  logic        an_error;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int ae_cnt = 0;

  seven_seg_demux #(
    .NUM_DIGITS    (6),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digit_seg   (digit_seg),
    .digit_hex   (digit_hex),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .an_error    (an_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (an_error)   ae_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] an, input logic [6:0] sg);
    an_in  = an;
    seg_in = sg;
  endtask

  localparam logic [5:0] AN_SEL [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  localparam logic [6:0] SWEEP  [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h08};

  initial begin
    // Reset with a blank bus
    drive(6'h3F, 7'h7F);
    #12;
    check("reset_seg",   digit_seg,   {6{7'h7F}});
    check("reset_hex",   digit_hex,   24'h0);
    check("reset_valid", digit_valid, 6'h0);
    rst_n = 1'b1;
    tick(10);
    check("blank_seg",   digit_seg,   {6{7'h7F}});
    check("blank_valid", digit_valid, 6'h0);
    check("blank_pulses", 64'(fd_cnt + ae_cnt), 64'd0);

    // Digit 0 shows '0': capture lands on the 6th edge
    drive(6'h3E, 7'h40);
    tick(5);
    check("d0_before_e6_valid", digit_valid, 6'h00);
    tick(1);
    check("d0_e6_valid", digit_valid, 6'h01);
    check("d0_e6_hex",   digit_hex[3:0], 4'h0);
    check("d0_e6_seg",   digit_seg[6:0], 7'h40);
    tick(4);
    check("d0_no_frame", 64'(fd_cnt), 64'd0);

    // Sweep 0..5; the frame closes on digit 5's capture
    for (int d = 0; d < 6; d++) begin
      drive(AN_SEL[d], SWEEP[d]);
      tick(6);
      if (d == 5) begin
        check("frame_pulse_on_d5", frame_done, 1'b1);
        tick(1);
        check("frame_pulse_width", frame_done, 1'b0);
        tick(1);
      end else begin
        tick(2);
      end
    end
    check("sweep_hex",   digit_hex,   24'hA54321);
    check("sweep_valid", digit_valid, 6'h3F);
    check("sweep_frames", 64'(fd_cnt), 64'd1);

    // Two-cycle glitch on digit 1 must be ignored
    drive(6'h3D, 7'h00);
    tick(2);
    drive(6'h3F, 7'h7F);
    tick(8);
    check("glitch_d1_seg", digit_seg[13:7], 7'h24);
    check("glitch_d1_hex", digit_hex[7:4],  4'h2);

    // Two anodes low: one error pulse, nothing written
    drive(6'h3C, 7'h40);
    tick(6);
    check("anerr_pulse", an_error, 1'b1);
    tick(1);
    check("anerr_width", an_error, 1'b0);
    tick(1);
    check("anerr_count", 64'(ae_cnt), 64'd1);
    check("anerr_seg_d0d1", digit_seg[13:0], {7'h24, 7'h79});
    check("anerr_hex", digit_hex, 24'hA54321);

    // Blank glyph on digit 2: raw stored, not valid
    drive(6'h3B, 7'h7F);
    tick(6);
    check("blank_d2_seg",   digit_seg[20:14], 7'h7F);
    check("blank_d2_hex",   digit_hex[11:8],  4'h0);
    check("blank_d2_valid", digit_valid,      6'h3B);
    tick(2);

    // Reset asserted mid-settling clears everything immediately
    drive(6'h3E, 7'h00);
    tick(3);
    rst_n = 1'b0;
    #2;
    check("midrst_seg",   digit_seg,   {6{7'h7F}});
    check("midrst_hex",   digit_hex,   24'h0);
    check("midrst_valid", digit_valid, 6'h0);
    check("midrst_pulses", {frame_done, an_error}, 2'b00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(6);
    check("post_rst_d0_hex",   digit_hex[3:0], 4'h8);
    check("post_rst_d0_valid", digit_valid,    6'h01);
    tick(4);
    check("final_frames", 64'(fd_cnt), 64'd1);
    check("final_anerr",  64'(ae_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
